// File: rtl/fft_pkg.sv
// Shared defaults, scheduler state encoding and a constant clog2 helper for the FFT butterfly scheduler.
package fft_pkg;

   localparam int unsigned LOG2N_DEF = 4;
   localparam int unsigned DW_DEF    = 24;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_GAP   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// DIF butterfly address/twiddle generator: inserts a zero bit into k at position LOG2N-1-stage
// to form the top operand, pairs it with the operand one span above, and scales the twiddle by stage.
module fft_addr_gen
   import fft_pkg::*;
#(
   parameter  int unsigned LOG2N = LOG2N_DEF,
   localparam int unsigned SW    = clog2(LOG2N),
   localparam int unsigned KW    = LOG2N - 1
) (
   input  logic [KW-1:0]    i_k,
   input  logic [SW-1:0]    i_stage,
   output logic [LOG2N-1:0] o_addr_a,
   output logic [LOG2N-1:0] o_addr_b,
   output logic [KW-1:0]    o_tw
);

   logic [LOG2N-1:0] w_k_ext;
   logic [LOG2N-1:0] w_span;
   logic [LOG2N-1:0] w_mask;
   logic [LOG2N-1:0] w_low;
   logic [LOG2N-1:0] w_addr_a;

   assign w_k_ext  = {1'b0, i_k};
   assign w_span   = LOG2N'(1) << (LOG2N'(LOG2N - 1) - LOG2N'(i_stage));
   assign w_mask   = w_span - LOG2N'(1);
   assign w_low    = w_k_ext & w_mask;
   // Bits of k above the insertion point move up by one to open the zero slot.
   assign w_addr_a = ((w_k_ext & ~w_mask) << 1) | w_low;

   assign o_addr_a = w_addr_a;
   assign o_addr_b = w_addr_a | w_span;
   assign o_tw     = KW'(w_low << i_stage);

endmodule

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIF FFT scheduler: walks stages and butterfly pairs, issues reads, writes the
// Butterfly results back one cycle later, and inserts a bubble between stages for RAW safety.
module fft_bfly_sched
   import fft_pkg::*;
#(
   parameter  int unsigned LOG2N = LOG2N_DEF,
   parameter  int unsigned DW    = DW_DEF,
   localparam int unsigned SW    = clog2(LOG2N),
   localparam int unsigned KW    = LOG2N - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   input  logic [DW-1:0]    rd_data_a,
   input  logic [DW-1:0]    rd_data_b,
   output logic [DW-1:0]    bf_a,
   output logic [DW-1:0]    bf_b,
   input  logic [DW-1:0]    bf_c1,
   input  logic [DW-1:0]    bf_c2,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b,
   output logic [DW-1:0]    wr_data_a,
   output logic [DW-1:0]    wr_data_b,
   output logic [KW-1:0]    tw_idx,
   output logic [SW-1:0]    stage
);

   localparam logic [KW-1:0] K_LAST     = {KW{1'b1}};
   localparam logic [SW-1:0] STAGE_LAST = SW'(LOG2N - 1);

   state_t           r_state;
   logic [KW-1:0]    r_k;
   logic [SW-1:0]    r_stage;
   logic             r_busy;
   logic             r_done;
   logic             r_rd_en;
   logic [LOG2N-1:0] r_rd_addr_a;
   logic [LOG2N-1:0] r_rd_addr_b;
   logic [KW-1:0]    r_rd_tw;
   logic             r_wr_en;
   logic [LOG2N-1:0] r_wr_addr_a;
   logic [LOG2N-1:0] r_wr_addr_b;
   logic [KW-1:0]    r_tw;

   logic [KW-1:0]    w_gen_k;
   logic [SW-1:0]    w_gen_stage;
   logic [LOG2N-1:0] w_gen_a;
   logic [LOG2N-1:0] w_gen_b;
   logic [KW-1:0]    w_gen_tw;

   // Generator looks at the pair that will be issued on the coming edge.
   assign w_gen_k     = (r_state == S_RUN) ? KW'(r_k + KW'(1)) : '0;
   assign w_gen_stage = (r_state == S_GAP) ? SW'(r_stage + SW'(1)) :
                        (r_state == S_RUN) ? r_stage : '0;

   fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
      .i_k      (w_gen_k),
      .i_stage  (w_gen_stage),
      .o_addr_a (w_gen_a),
      .o_addr_b (w_gen_b),
      .o_tw     (w_gen_tw)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_stage     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rd_en     <= 1'b0;
         r_rd_addr_a <= '0;
         r_rd_addr_b <= '0;
         r_rd_tw     <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr_a <= '0;
         r_wr_addr_b <= '0;
         r_tw        <= '0;
      end else begin
         r_done      <= 1'b0;
         r_rd_en     <= 1'b0;
         r_wr_en     <= r_rd_en;
         r_wr_addr_a <= r_rd_addr_a;
         r_wr_addr_b <= r_rd_addr_b;
         r_tw        <= r_rd_tw;
         if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_wr_en <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_state     <= S_RUN;
                     r_busy      <= 1'b1;
                     r_k         <= '0;
                     r_stage     <= '0;
                     r_rd_en     <= 1'b1;
                     r_rd_addr_a <= w_gen_a;
                     r_rd_addr_b <= w_gen_b;
                     r_rd_tw     <= w_gen_tw;
                  end
               end
               S_RUN: begin
                  if (r_k == K_LAST) begin
                     r_state <= (r_stage == STAGE_LAST) ? S_DRAIN : S_GAP;
                  end else begin
                     r_k         <= w_gen_k;
                     r_rd_en     <= 1'b1;
                     r_rd_addr_a <= w_gen_a;
                     r_rd_addr_b <= w_gen_b;
                     r_rd_tw     <= w_gen_tw;
                  end
               end
               S_GAP: begin
                  r_state     <= S_RUN;
                  r_stage     <= w_gen_stage;
                  r_k         <= '0;
                  r_rd_en     <= 1'b1;
                  r_rd_addr_a <= w_gen_a;
                  r_rd_addr_b <= w_gen_b;
                  r_rd_tw     <= w_gen_tw;
               end
               S_DRAIN: begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
               S_DONE: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign rd_en     = r_rd_en;
   assign rd_addr_a = r_rd_addr_a;
   assign rd_addr_b = r_rd_addr_b;
   assign wr_en     = r_wr_en;
   assign wr_addr_a = r_wr_addr_a;
   assign wr_addr_b = r_wr_addr_b;
   assign tw_idx    = r_tw;
   assign stage     = r_stage;

   assign bf_a      = rd_data_a;
   assign bf_b      = rd_data_b;
   assign wr_data_a = bf_c1;
   assign wr_data_b = bf_c2;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Directed bench for fft_bfly_sched: per-cycle schedule checks, sum/diff memory model results,
// abort, held start and asynchronous reset behaviour for N=16.
module tb_fft_bfly_sched;
   import fft_pkg::*;

   localparam int unsigned LOG2N = 4;
   localparam int unsigned N     = 16;
   localparam int unsigned DW    = 24;
   localparam int unsigned SW    = 2;
   localparam int unsigned NC    = 46;

   logic             clk = 1'b0;
   logic             rst, start, abort;
   logic             busy, done, rd_en, wr_en;
   logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [DW-1:0]    rd_data_a, rd_data_b, bf_a, bf_b, bf_c1, bf_c2, wr_data_a, wr_data_b;
   logic [LOG2N-2:0] tw_idx;
   logic [SW-1:0]    stage;

   fft_bfly_sched #(.LOG2N(LOG2N), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .bf_a(bf_a), .bf_b(bf_b),
      .bf_c1(bf_c1), .bf_c2(bf_c2), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
      .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .tw_idx(tw_idx), .stage(stage)
   );

   always #5 clk = ~clk;

   // Butterfly model: per-component sum/difference, twiddle not applied.
   assign bf_c1 = {bf_a[23:12] + bf_b[23:12], bf_a[11:0] + bf_b[11:0]};
   assign bf_c2 = {bf_a[23:12] - bf_b[23:12], bf_a[11:0] - bf_b[11:0]};

   logic [DW-1:0] mem [N];
   logic          ld;
   logic [DW-1:0] ld_v0, ld_vr;

   always @(posedge clk) begin
      if (ld) begin
         for (int i = 0; i < N; i++) mem[i] <= (i == 0) ? ld_v0 : ld_vr;
      end else begin
         if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
         end
         if (wr_en) begin
            mem[wr_addr_a] <= wr_data_a;
            mem[wr_addr_b] <= wr_data_b;
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   bit e_rd [NC];
   bit e_wr [NC];
   int e_a  [NC];
   int e_b  [NC];
   int e_st [NC];
   int e_wa [NC];
   int e_wb [NC];
   int e_tw [NC];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Expected schedule enumerated as groups of 2*span with a running pair counter.
   task automatic build_expect();
      for (int c = 0; c < NC; c++) begin
         e_rd[c] = 0; e_wr[c] = 0; e_a[c] = 0; e_b[c] = 0;
         e_st[c] = 0; e_wa[c] = 0; e_wb[c] = 0; e_tw[c] = 0;
      end
      for (int s = 0; s < 4; s++) begin
         int span, k;
         span = N >> (s + 1);
         k = 0;
         for (int g = 0; g < N / (2 * span); g++) begin
            for (int j = 0; j < span; j++) begin
               int c;
               c = 1 + s * 9 + k;
               e_rd[c] = 1; e_a[c] = g * 2 * span + j; e_b[c] = e_a[c] + span; e_st[c] = s;
               e_wr[c+1] = 1; e_wa[c+1] = e_a[c]; e_wb[c+1] = e_b[c]; e_tw[c+1] = j << s;
               k++;
            end
         end
      end
   endtask

   task automatic load_mem(input logic [DW-1:0] v0, input logic [DW-1:0] vr);
      ld_v0 = v0; ld_vr = vr; ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
   endtask

   // Entered at the sample point of cycle 1; leaves at the sample point of cycle 39.
   task automatic run_full();
      for (int c = 1; c <= 38; c++) begin
         cyc = c;
         check("busy", 32'(busy), 32'(c <= 37));
         check("done", 32'(done), 32'(c == 37));
         check("rd_en", 32'(rd_en), 32'(e_rd[c]));
         if (e_rd[c]) begin
            check("rd_addr_a", 32'(rd_addr_a), 32'(e_a[c]));
            check("rd_addr_b", 32'(rd_addr_b), 32'(e_b[c]));
            check("stage", 32'(stage), 32'(e_st[c]));
         end
         check("wr_en", 32'(wr_en), 32'(e_wr[c]));
         if (e_wr[c]) begin
            check("wr_addr_a", 32'(wr_addr_a), 32'(e_wa[c]));
            check("wr_addr_b", 32'(wr_addr_b), 32'(e_wb[c]));
            check("tw_idx", 32'(tw_idx), 32'(e_tw[c]));
         end
         if (rd_en && wr_en)
            check("raw_overlap", 32'(rd_addr_a == wr_addr_a || rd_addr_a == wr_addr_b ||
                                     rd_addr_b == wr_addr_a || rd_addr_b == wr_addr_b), 32'd0);
         @(negedge clk);
      end
   endtask

   initial begin
      int dcnt;
      build_expect();
      rst = 1'b1; start = 1'b0; abort = 1'b0; ld = 1'b0; ld_v0 = '0; ld_vr = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_addrs", 32'({rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b}), 32'd0);
      check("rst_tw", 32'(tw_idx), 32'd0);
      check("rst_stage", 32'(stage), 32'd0);

      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("start_abort_busy", 32'(busy), 32'd0);
      check("start_abort_rd_en", 32'(rd_en), 32'd0);

      // Impulse: every bin equals the impulse value.
      load_mem(24'h001000, 24'h000000);
      start = 1'b1; @(negedge clk); start = 1'b0;
      run_full();
      for (int i = 0; i < N; i++) check("impulse_bin", 32'(mem[i]), 32'h001000);

      // Constant input: all energy lands in bin 0 (16 * re=1).
      load_mem(24'h001000, 24'h001000);
      start = 1'b1; @(negedge clk); start = 1'b0;
      run_full();
      for (int i = 0; i < N; i++) check("const_bin", 32'(mem[i]), (i == 0) ? 32'h010000 : 32'h0);

      // Abort sampled at the end of cycle 12.
      load_mem(24'h001000, 24'h000000);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (11) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      cyc = 13;
      check("abort_rd_en", 32'(rd_en), 32'd0);
      check("abort_wr_en", 32'(wr_en), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) dcnt++;
         @(negedge clk);
      end
      check("abort_quiet", 32'(dcnt), 32'd0);

      load_mem(24'h001000, 24'h000000);
      start = 1'b1; @(negedge clk); start = 1'b0;
      run_full();
      check("fresh_bin0", 32'(mem[0]), 32'h001000);
      check("fresh_bin15", 32'(mem[15]), 32'h001000);

      // Held start: one transform, one idle cycle, then a second transform.
      start = 1'b1; @(negedge clk);
      run_full();
      cyc = 39;
      check("hold_restart_busy", 32'(busy), 32'd1);
      check("hold_restart_rd_en", 32'(rd_en), 32'd1);
      check("hold_restart_rd_b", 32'(rd_addr_b), 32'd8);
      start = 1'b0;
      repeat (19) @(negedge clk);
      cyc = 20;
      check("pre_rst_stage", 32'(stage), 32'd2);
      rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_rd_en", 32'(rd_en), 32'd0);
      check("async_rst_wr_en", 32'(wr_en), 32'd0);
      check("async_rst_addr", 32'({rd_addr_a, rd_addr_b, wr_addr_a}), 32'd0);
      check("async_rst_stage", 32'(stage), 32'd0);
      check("async_rst_tw", 32'(tw_idx), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
